interrupt_dispatcher: RTL and testbench

- CPU-side partner of the interrupt request/attention manager.
- Decides at which instruction boundary a pending interrupt is taken. It then drives the one-hot s_calli/s_reti strobes back to the manager and redirects the PC to the vector or the saved return address.
- Keeps a LIFO of return PCs so higher-priority interrupts can nest.
- Sits between the manager, the control unit (decoded reti, global enable) and the PC mux.

---
 rtl/interrupt_dispatcher_pkg.sv | 42 ++++
 rtl/interrupt_dispatcher_return_stack.sv | 69 ++++++
 rtl/interrupt_dispatcher.sv | 122 ++++++++++++
 tb/tb_interrupt_dispatcher.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_dispatcher_pkg.sv
// Shared definitions for the interrupt dispatcher slice.
//   - Default sizes for the interrupt line count, PC width and return-stack depth.
//   - Dispatcher state encoding.
//   - Priority helpers. Bit 0 is the highest priority.
//     Vectors are passed zero-extended to MaxWidth bits.
package interrupt_dispatcher_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultAddrW = 10;
  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned MaxWidth     = 32;

  typedef enum logic {
    StRun   = 1'b0,
    StGuard = 1'b1
  } state_e;

  // Isolates the lowest set bit. Two's-complement trick: vec & -vec.
  function automatic logic [MaxWidth-1:0] lowest_set_onehot(input logic [MaxWidth-1:0] vec);
    return vec & (~vec + 32'd1);
  endfunction

  // Index of the lowest set bit among the first `width` bits.
  // Returns `width` when no bit is set.
  function automatic int unsigned lowest_set_index(input logic [MaxWidth-1:0] vec,
                                                   input int unsigned         width);
    int unsigned         idx;
    logic                found;
    logic [MaxWidth-1:0] sh;
    idx   = width;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      sh = vec >> i;
      if (!found && (i < width) && sh[0]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_dispatcher_return_stack.sv
// LIFO of return PCs used for nested interrupts.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset; empties the stack
//   push_i   : push data_i (ignored when full)
//   pop_i    : pop the top entry (ignored when empty)
//   data_i   : PC to push
//   top_o    : current top entry, combinational; undefined when empty
//   count_o  : number of valid entries, 0..DEPTH
module interrupt_dispatcher_return_stack #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ADDR_W-1:0]        data_i,
  output logic [ADDR_W-1:0]        top_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]   Full   = (PtrW+1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PtrW:0]     count_q, count_d;
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign wr_ptr  = count_q[PtrW-1:0];
  assign rd_ptr  = wr_ptr - PtrOne;
  assign push_ok = push_i && (count_q != Full);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push_ok) begin
      count_d = count_q + CntOne;
    end else if (pop_ok) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty stack never exposes stale entries.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  assign top_o   = mem_q[rd_ptr];
  assign count_o = count_q;

  // The dispatcher pushes only on take and pops only on reti.
  // Those two are mutually exclusive.
  push_pop_exclusive_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && pop_i));

endmodule

// File: rtl/interrupt_dispatcher.sv
// CPU-side interrupt dispatcher. It decides at which instruction boundary a
// pending interrupt is taken, strobes the manager, and redirects the PC.
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   int_s       : pending requests from the manager
//   int_a       : in-service sources from the manager
//   vec_addr    : handler vector, valid while s_calli is asserted
//   pc_next     : sequential next PC, pushed as the return address
//   instr_reti  : current instruction is a return-from-interrupt
//   int_en      : global interrupt enable
//   s_calli     : one-hot take strobe
//   s_reti      : one-hot service-finished strobe
//   pc_override : select pc_target instead of pc_next
//   pc_target   : vector or popped return address
//   nest_depth  : return-stack occupancy
//   reti_err    : sticky flag, set by a reti with nothing to return to
module interrupt_dispatcher
  import interrupt_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DEPTH  = DefaultDepth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       int_s,
  input  logic [WIDTH-1:0]       int_a,
  input  logic [ADDR_W-1:0]      vec_addr,
  input  logic [ADDR_W-1:0]      pc_next,
  input  logic                   instr_reti,
  input  logic                   int_en,
  output logic [WIDTH-1:0]       s_calli,
  output logic [WIDTH-1:0]       s_reti,
  output logic                   pc_override,
  output logic [ADDR_W-1:0]      pc_target,
  output logic [$clog2(DEPTH):0] nest_depth,
  output logic                   reti_err
);

  state_e                state_q;
  logic                  reti_err_q;
  logic [WIDTH-1:0]      cand;
  logic [MaxWidth-1:0]   cand_ext, int_a_ext;
  int unsigned           c_idx, a_idx;
  logic                  take, reti_ok;
  logic [ADDR_W-1:0]     stack_top;
  logic [$clog2(DEPTH):0] depth;

  assign cand = int_s & ~int_a;

  always_comb begin
    cand_ext              = '0;
    int_a_ext             = '0;
    cand_ext[WIDTH-1:0]   = cand;
    int_a_ext[WIDTH-1:0]  = int_a;
  end

  assign c_idx = lowest_set_index(cand_ext, WIDTH);
  assign a_idx = lowest_set_index(int_a_ext, WIDTH);

  // A reti needs both a source in service and a saved PC.
  // If either is missing, the reti only raises reti_err.
  assign reti_ok = instr_reti && (int_a != '0) && (depth != '0);

  // Only a strictly higher-priority source preempts the one in service.
  // GUARD holds off a take for one cycle, so the first handler (or
  // post-return) instruction always executes.
  assign take = int_en && (cand != '0) && (c_idx < a_idx) && (32'(depth) < DEPTH) &&
                (state_q == StRun) && !instr_reti;

  interrupt_dispatcher_return_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_return_stack (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (take),
    .pop_i   (reti_ok),
    .data_i  (pc_next),
    .top_o   (stack_top),
    .count_o (depth)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      reti_err_q <= 1'b0;
    end else begin
      state_q <= (take || reti_ok) ? StGuard : StRun;
      if (instr_reti && !reti_ok) begin
        reti_err_q <= 1'b1;
      end
    end
  end

  // Redirect is combinational so it lands in the decision cycle.
  // Gated by reset so nothing leaks out while reset is held.
  always_comb begin
    s_calli     = '0;
    s_reti      = '0;
    pc_override = 1'b0;
    pc_target   = '0;
    if (reset) begin
      if (reti_ok) begin
        s_reti      = WIDTH'(lowest_set_onehot(int_a_ext));
        pc_override = 1'b1;
        pc_target   = stack_top;
      end else if (take) begin
        s_calli     = WIDTH'(lowest_set_onehot(cand_ext));
        pc_override = 1'b1;
        pc_target   = vec_addr;
      end
    end
  end

  assign nest_depth = depth;
  assign reti_err   = reti_err_q;

  strobes_exclusive_a: assert property (@(posedge clk) disable iff (!reset)
    !((|s_calli) && (|s_reti)));

endmodule

// File: tb/tb_interrupt_dispatcher.sv
module tb_interrupt_dispatcher;

  localparam int W  = 8;
  localparam int AW = 10;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  int_s, int_a, s_calli, s_reti;
  logic [AW-1:0] vec_addr, pc_next, pc_target;
  logic          instr_reti, int_en, pc_override, reti_err;
  logic [3:0]    nest_depth;
  logic [26:0]   obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  interrupt_dispatcher #(.WIDTH(W), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .int_s       (int_s),
    .int_a       (int_a),
    .vec_addr    (vec_addr),
    .pc_next     (pc_next),
    .instr_reti  (instr_reti),
    .int_en      (int_en),
    .s_calli     (s_calli),
    .s_reti      (s_reti),
    .pc_override (pc_override),
    .pc_target   (pc_target),
    .nest_depth  (nest_depth),
    .reti_err    (reti_err)
  );

  assign obs = {s_calli, s_reti, pc_override, pc_target};

  function automatic logic [26:0] pack(input logic [7:0] sc, input logic [7:0] sr,
                                       input logic ov, input logic [9:0] tgt);
    return {sc, sr, ov, tgt};
  endfunction

  task automatic drive(input logic en, input logic [7:0] s, input logic [7:0] a,
                       input logic r, input logic [9:0] pcn, input logic [9:0] vec);
    int_en = en; int_s = s; int_a = a; instr_reti = r; pc_next = pcn; vec_addr = vec;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive(0, 8'h00, 8'h00, 0, 10'h000, 10'h000);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    drive(1, 8'hFF, 8'h00, 1, 10'h123, 10'h3FF);
    @(negedge clk);
    checks++;
    if (obs !== 27'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", obs, 27'd0);
    end
    checks++;
    if ({nest_depth, reti_err} !== 5'd0) begin
      errors++; $display("FAIL reset_state got %h exp %h", {nest_depth, reti_err}, 5'd0);
    end
    drive(0, 8'h00, 8'h00, 0, 10'h000, 10'h000);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_call_return();
    apply_reset();
    drive(1, 8'h04, 8'h00, 0, 10'h020, 10'h215);
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h04, 8'h00, 1, 10'h215)) begin
      errors++; $display("FAIL call_strobe got %h exp %h", obs, pack(8'h04, 8'h00, 1, 10'h215));
    end
    next_cycle();
    drive(1, 8'h01, 8'h04, 0, 10'h021, 10'h111);
    @(negedge clk);
    checks++;
    if (obs !== 27'd0) begin
      errors++; $display("FAIL guard_blocks_take got %h exp %h", obs, 27'd0);
    end
    checks++;
    if (nest_depth !== 4'd1) begin
      errors++; $display("FAIL guard_depth got %0d exp 1", nest_depth);
    end
    next_cycle();
    drive(1, 8'h01, 8'h04, 1, 10'h030, 10'h111);
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h00, 8'h04, 1, 10'h020)) begin
      errors++; $display("FAIL reti_strobe got %h exp %h", obs, pack(8'h00, 8'h04, 1, 10'h020));
    end
    next_cycle();
    drive(1, 8'h02, 8'h00, 0, 10'h021, 10'h155);
    @(negedge clk);
    checks++;
    if ({obs, nest_depth} !== {27'd0, 4'd0}) begin
      errors++; $display("FAIL post_reti_guard got %h/%0d exp 0/0", obs, nest_depth);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h02, 8'h00, 1, 10'h155)) begin
      errors++; $display("FAIL run_after_guard got %h exp %h", obs, pack(8'h02, 8'h00, 1, 10'h155));
    end
    next_cycle();
  endtask

  task automatic test_nesting();
    apply_reset();
    drive(1, 8'h04, 8'h00, 0, 10'h030, 10'h100);
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h04, 8'h00, 1, 10'h100)) begin
      errors++; $display("FAIL nest_first_call got %h exp %h", obs, pack(8'h04, 8'h00, 1, 10'h100));
    end
    next_cycle();
    drive(1, 8'h00, 8'h04, 0, 10'h101, 10'h000);
    next_cycle();
    drive(1, 8'h05, 8'h04, 0, 10'h101, 10'h200);
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h01, 8'h00, 1, 10'h200)) begin
      errors++; $display("FAIL nest_preempt got %h exp %h", obs, pack(8'h01, 8'h00, 1, 10'h200));
    end
    next_cycle();
    drive(1, 8'h04, 8'h05, 0, 10'h201, 10'h000);
    next_cycle();
    drive(1, 8'h0D, 8'h05, 0, 10'h201, 10'h2AA);
    @(negedge clk);
    checks++;
    if ({obs, nest_depth} !== {27'd0, 4'd2}) begin
      errors++; $display("FAIL lower_prio_waits got %h/%0d exp 0/2", obs, nest_depth);
    end
    next_cycle();
    drive(1, 8'h0D, 8'h05, 1, 10'h202, 10'h000);
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h00, 8'h01, 1, 10'h101)) begin
      errors++; $display("FAIL nest_reti_inner got %h exp %h", obs, pack(8'h00, 8'h01, 1, 10'h101));
    end
    next_cycle();
    drive(1, 8'h0C, 8'h04, 0, 10'h102, 10'h000);
    next_cycle();
    drive(1, 8'h0C, 8'h04, 1, 10'h103, 10'h000);
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h00, 8'h04, 1, 10'h030)) begin
      errors++; $display("FAIL nest_reti_outer got %h exp %h", obs, pack(8'h00, 8'h04, 1, 10'h030));
    end
    next_cycle();
    drive(1, 8'h00, 8'h00, 0, 10'h031, 10'h000);
    @(negedge clk);
    checks++;
    if (nest_depth !== 4'd0) begin
      errors++; $display("FAIL nest_unwound got %0d exp 0", nest_depth);
    end
    next_cycle();
  endtask

  task automatic test_enable();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'hFF, 8'h00, 0, 10'h050, 10'h3C0);
      @(negedge clk);
      checks++;
      if (obs !== 27'd0) begin
        errors++; $display("FAIL disabled_no_take cycle %0d got %h exp 0", i, obs);
      end
      next_cycle();
    end
    drive(1, 8'hFF, 8'h00, 0, 10'h050, 10'h3C0);
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h01, 8'h00, 1, 10'h3C0)) begin
      errors++; $display("FAIL enable_take got %h exp %h", obs, pack(8'h01, 8'h00, 1, 10'h3C0));
    end
    next_cycle();
  endtask

  task automatic test_stack_full_and_err();
    logic [7:0] amask, bitv;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      amask = 8'(16'hFF00 >> k);
      bitv  = 8'(1 << (7 - k));
      drive(1, amask | bitv, amask, 0, 10'(10'h100 + k), 10'(10'h200 + k));
      @(negedge clk);
      checks++;
      if (obs !== pack(bitv, 8'h00, 1, 10'(10'h200 + k))) begin
        errors++; $display("FAIL fill_call %0d got %h exp %h", k, obs,
                           pack(bitv, 8'h00, 1, 10'(10'h200 + k)));
      end
      next_cycle();
      drive(1, 8'h00, amask | bitv, 0, 10'h000, 10'h000);
      next_cycle();
    end
    drive(1, 8'hFF, 8'h80, 0, 10'h1FF, 10'h3FF);
    @(negedge clk);
    checks++;
    if ({obs, nest_depth} !== {27'd0, 4'd8}) begin
      errors++; $display("FAIL full_holds got %h/%0d exp 0/8", obs, nest_depth);
    end
    next_cycle();
    drive(1, 8'h00, 8'h00, 1, 10'h000, 10'h000);
    @(negedge clk);
    checks++;
    if ({obs, nest_depth} !== {27'd0, 4'd8}) begin
      errors++; $display("FAIL bad_reti_no_action got %h/%0d exp 0/8", obs, nest_depth);
    end
    next_cycle();
    drive(1, 8'h00, 8'hFF, 1, 10'h000, 10'h000);
    @(negedge clk);
    checks++;
    if (reti_err !== 1'b1) begin
      errors++; $display("FAIL reti_err_set got %b exp 1", reti_err);
    end
    checks++;
    if (obs !== pack(8'h00, 8'h01, 1, 10'h107)) begin
      errors++; $display("FAIL full_reti_top got %h exp %h", obs, pack(8'h00, 8'h01, 1, 10'h107));
    end
    next_cycle();
    drive(1, 8'h00, 8'hFE, 0, 10'h000, 10'h000);
    @(negedge clk);
    checks++;
    if ({reti_err, nest_depth} !== {1'b1, 4'd7}) begin
      errors++; $display("FAIL reti_err_sticky got %b/%0d exp 1/7", reti_err, nest_depth);
    end
    next_cycle();
    apply_reset();
    @(negedge clk);
    checks++;
    if (reti_err !== 1'b0) begin
      errors++; $display("FAIL reti_err_cleared got %b exp 0", reti_err);
    end
    next_cycle();
    drive(1, 8'h00, 8'h04, 1, 10'h000, 10'h000);
    @(negedge clk);
    checks++;
    if (obs !== 27'd0) begin
      errors++; $display("FAIL empty_reti_no_strobe got %h exp 0", obs);
    end
    next_cycle();
    drive(0, 8'h00, 8'h00, 0, 10'h000, 10'h000);
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (reti_err !== 1'b1) begin
      errors++; $display("FAIL empty_reti_err got %b exp 1", reti_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_guard();
    apply_reset();
    drive(1, 8'h04, 8'h00, 0, 10'h010, 10'h300);
    next_cycle();
    drive(1, 8'h00, 8'h04, 0, 10'h000, 10'h000);
    next_cycle();
    drive(1, 8'h06, 8'h04, 0, 10'h301, 10'h310);
    next_cycle();
    drive(1, 8'h00, 8'h06, 0, 10'h000, 10'h000);
    next_cycle();
    drive(1, 8'h07, 8'h06, 0, 10'h311, 10'h320);
    next_cycle();
    // Now in GUARD with three saved PCs; a reti is still honoured here.
    drive(1, 8'h07, 8'h07, 1, 10'h321, 10'h000);
    #1;
    checks++;
    if ({obs, nest_depth} !== {pack(8'h00, 8'h01, 1, 10'h311), 4'd3}) begin
      errors++; $display("FAIL reti_in_guard got %h/%0d exp %h/3", obs, nest_depth,
                         pack(8'h00, 8'h01, 1, 10'h311));
    end
    drive(1, 8'h01, 8'h00, 0, 10'h000, 10'h3AA);
    reset = 1'b0;
    #1;
    checks++;
    if ({obs, nest_depth} !== {27'd0, 4'd0}) begin
      errors++; $display("FAIL async_reset got %h/%0d exp 0/0", obs, nest_depth);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== pack(8'h01, 8'h00, 1, 10'h3AA)) begin
      errors++; $display("FAIL run_after_reset got %h exp %h", obs, pack(8'h01, 8'h00, 1, 10'h3AA));
    end
    next_cycle();
  endtask

  task automatic test_random();
    logic [9:0] stk[$];
    bit         guard, err, en, r, er, et;
    logic [7:0] s, a, cand, esc, esr;
    logic [9:0] pcn, vec, etg;
    int         c, ai, depth;
    apply_reset();
    stk.delete();
    guard = 0;
    err   = 0;
    for (int n = 0; n < 400; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      s   = 8'($urandom);
      a   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      r   = ($urandom_range(0, 5) == 0);
      pcn = 10'($urandom);
      vec = 10'($urandom);
      cand = s & ~a;
      c = W;
      ai = W;
      for (int i = W - 1; i >= 0; i--) begin
        if (cand[i]) c = i;
        if (a[i]) ai = i;
      end
      depth = stk.size();
      er = r && (a != 0) && (depth > 0);
      et = en && (cand != 0) && (c < ai) && (depth < D) && !guard && !r;
      esc = et ? 8'(1 << c) : 8'h00;
      esr = er ? 8'(1 << ai) : 8'h00;
      etg = er ? stk[$] : (et ? vec : 10'h000);
      drive(en, s, a, r, pcn, vec);
      @(negedge clk);
      checks++;
      if (obs !== pack(esc, esr, er | et, etg)) begin
        errors++; $display("FAIL random_out step %0d got %h exp %h", n, obs,
                           pack(esc, esr, er | et, etg));
      end
      checks++;
      if ({nest_depth, reti_err} !== {4'(depth), err}) begin
        errors++; $display("FAIL random_state step %0d got %0d/%b exp %0d/%b", n,
                           nest_depth, reti_err, depth, err);
      end
      next_cycle();
      if (er) void'(stk.pop_back());
      if (et) stk.push_back(pcn);
      guard = er | et;
      if (r && !er) err = 1;
    end
  endtask

  initial begin
    drive(0, 8'h00, 8'h00, 0, 10'h000, 10'h000);
    test_reset();
    test_call_return();
    test_nesting();
    test_enable();
    test_stack_full_and_err();
    test_reset_mid_guard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
